// File: rtl/ga_pkg.sv
// Shared GA accelerator types: chromosome geometry, crossover FSM states and the
// per-weight crossover mux used by the crossover stage.
package ga_pkg;

  localparam int unsigned DATA_W      = 6;
  localparam int unsigned M_MAX       = 32;
  localparam int unsigned M_MAX_W     = $clog2(M_MAX + 1);
  localparam int unsigned M_IDX_MAX_W = $clog2(M_MAX);
  localparam int unsigned CHROM_MAX_W = DATA_W * M_MAX;
  localparam int unsigned RAND_W      = M_IDX_MAX_W + DATA_W;

  typedef logic [CHROM_MAX_W-1:0] chrom_t;
  typedef logic [M_MAX_W-1:0]     wcnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StMod,
    StSendA,
    StSendB
  } xover_state_e;

  // Weights below k come from head, the rest from tail; weights at or above m are zeroed.
  function automatic chrom_t cross_mux(chrom_t head, chrom_t tail, wcnt_t m, wcnt_t k);
    chrom_t c;
    c = '0;
    for (int unsigned i = 0; i < M_MAX; i++) begin
      if (i < 32'(m)) begin
        c[i*DATA_W +: DATA_W] = (i < 32'(k)) ? head[i*DATA_W +: DATA_W]
                                             : tail[i*DATA_W +: DATA_W];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ga_crossover_if.sv
// Handshake bundle between selection, crossover and mutation stages: one parent pair
// in over parents_valid/parents_ack, one child at a time out over child_valid/child_ack.
interface ga_crossover_if;
  import ga_pkg::*;

  logic   parents_valid;
  logic   parents_ack;
  chrom_t parent1;
  chrom_t parent2;
  logic   child_valid;
  logic   child_ack;
  chrom_t child;

  modport master (
    output parents_valid, parent1, parent2, child_ack,
    input  parents_ack, child_valid, child
  );

  modport slave (
    input  parents_valid, parent1, parent2, child_ack,
    output parents_ack, child_valid, child
  );

endinterface

// File: rtl/ga_crossover_point.sv
// Sequential modulo for the cut point: k = (rand mod (m-1)) + 1, one subtraction per cycle.
// With m <= 1 there is no valid cut, so it finishes at once and reports k = 1.
module ga_crossover_point
  import ga_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst_i,
  input  logic                   load_i,
  input  logic [M_IDX_MAX_W-1:0] load_val_i,
  input  logic                   run_i,
  input  wcnt_t                  m_i,
  output logic                   done_o,
  output wcnt_t                  k_o
);

  logic [M_IDX_MAX_W-1:0] rem_q, rem_d;
  wcnt_t                  d;
  logic                   no_cut;

  assign d      = m_i - wcnt_t'(1);
  assign no_cut = (m_i <= wcnt_t'(1));
  assign done_o = no_cut || (wcnt_t'(rem_q) < d);
  assign k_o    = no_cut ? wcnt_t'(1) : wcnt_t'(rem_q) + wcnt_t'(1);

  // d always fits the remainder width whenever a subtraction actually happens.
  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = load_val_i;
    end else if (run_i && !done_o) begin
      rem_d = rem_q - M_IDX_MAX_W'(d);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q <= '0;
    end else if (sw_rst_i) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ga_crossover.sv
// Single-point crossover stage: captures a parent pair, draws a cut point and hands
// child A then child B to the mutation stage.
module ga_crossover
  import ga_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                sw_rst_i,
  input  wcnt_t               cnfg_m_i,
  input  logic [RAND_W-1:0]   rand_data_i,
  ga_crossover_if.slave       bus_io
);

  xover_state_e state_q, state_d;

  chrom_t p1_q, p1_d;
  chrom_t p2_q, p2_d;
  chrom_t child_q, child_d;
  chrom_t child_b_q, child_b_d;
  logic   parents_ack_q, parents_ack_d;
  logic   child_valid_q, child_valid_d;

  logic  pt_load, pt_run, pt_done;
  wcnt_t cut_k;
  wcnt_t m_eff;
  logic  unused_rand;

  assign unused_rand = ^rand_data_i[RAND_W-1:M_IDX_MAX_W];

  // m = 0 behaves like m = 1: weight 0 passes straight through each parent.
  assign m_eff = (cnfg_m_i == '0) ? wcnt_t'(1) : cnfg_m_i;

  ga_crossover_point u_point (
    .clk        (clk),
    .rstn       (rstn),
    .sw_rst_i   (sw_rst_i),
    .load_i     (pt_load),
    .load_val_i (rand_data_i[M_IDX_MAX_W-1:0]),
    .run_i      (pt_run),
    .m_i        (cnfg_m_i),
    .done_o     (pt_done),
    .k_o        (cut_k)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else if (sw_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.parents_valid) state_d = StMod;
      StMod:   if (pt_done)              state_d = StSendA;
      StSendA: if (bus_io.child_ack)     state_d = StSendB;
      StSendB: if (bus_io.child_ack)     state_d = StIdle;
      default:                           state_d = StIdle;
    endcase
  end

  always_comb begin
    pt_load       = 1'b0;
    pt_run        = 1'b0;
    p1_d          = p1_q;
    p2_d          = p2_q;
    child_d       = child_q;
    child_b_d     = child_b_q;
    parents_ack_d = 1'b0;
    child_valid_d = child_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.parents_valid) begin
          pt_load       = 1'b1;
          p1_d          = bus_io.parent1;
          p2_d          = bus_io.parent2;
          parents_ack_d = 1'b1;
        end
      end
      StMod: begin
        pt_run = 1'b1;
        if (pt_done) begin
          child_d       = cross_mux(p1_q, p2_q, m_eff, cut_k);
          child_b_d     = cross_mux(p2_q, p1_q, m_eff, cut_k);
          child_valid_d = 1'b1;
        end
      end
      StSendA: begin
        if (bus_io.child_ack) child_d = child_b_q;
      end
      StSendB: begin
        if (bus_io.child_ack) child_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_q          <= '0;
      p2_q          <= '0;
      child_q       <= '0;
      child_b_q     <= '0;
      parents_ack_q <= 1'b0;
      child_valid_q <= 1'b0;
    end else if (sw_rst_i) begin
      p1_q          <= '0;
      p2_q          <= '0;
      child_q       <= '0;
      child_b_q     <= '0;
      parents_ack_q <= 1'b0;
      child_valid_q <= 1'b0;
    end else begin
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      child_q       <= child_d;
      child_b_q     <= child_b_d;
      parents_ack_q <= parents_ack_d;
      child_valid_q <= child_valid_d;
    end
  end

  assign bus_io.parents_ack = parents_ack_q;
  assign bus_io.child_valid = child_valid_q;
  assign bus_io.child       = child_q;

endmodule
